cache_arbiter: RTL and testbench

Arbitrates the single physical-memory port between the instruction cache and the data cache of the pipelined LC-3b core. Each cache issues line-sized read or write requests. The arbiter grants one requester at a time, forwards its command, address and data to memory, and routes the memory response back to that requester only. It sits between the two L1 caches and physical memory (or a future L2) and owns no datapath state beyond the grant.

---
 rtl/cache_arbiter_pkg.sv | 21 ++
 rtl/cache_arbiter.sv | 101 ++++++++++
 tb/tb_cache_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_pkg.sv
// Shared LC-3b memory-side types and the L1-to-memory arbiter state encoding.
package cache_arbiter_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LINE_W = 128;

  typedef logic [ADDR_W-1:0] lc3b_word;
  typedef logic [LINE_W-1:0] lc3b_line;

  typedef enum logic [1:0] {
    arb_idle,
    arb_serve_i,
    arb_serve_d
  } lc3b_arb_state;

  typedef enum logic {
    grant_icache,
    grant_dcache
  } arb_grant_e;

endpackage

// File: rtl/cache_arbiter.sv
// Shares the single physical-memory port between the icache and dcache,
// alternating grants under contention and steering the response to the owner.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W,
  parameter int unsigned LINE_WIDTH = LINE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  lc3b_arb_state r_state;
  lc3b_arb_state w_state_nxt;
  arb_grant_e    r_last_grant;
  arb_grant_e    w_last_grant_nxt;
  logic          w_i_req;
  logic          w_d_req;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

  // Read data fans out to both caches; only the resp pulse is steered.
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= arb_idle;
      r_last_grant <= grant_icache;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Memory commands depend only on the registered grant, never on pmem_resp.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = '0;
    pmem_wdata       = '0;
    i_resp           = 1'b0;
    d_resp           = 1'b0;

    case (r_state)
      arb_idle: begin
        if (w_i_req && w_d_req) begin
          w_state_nxt = (r_last_grant == grant_icache) ? arb_serve_d : arb_serve_i;
        end else if (w_i_req) begin
          w_state_nxt = arb_serve_i;
        end else if (w_d_req) begin
          w_state_nxt = arb_serve_d;
        end
      end

      arb_serve_i: begin
        pmem_read    = 1'b1;
        pmem_address = i_address;
        if (pmem_resp) begin
          i_resp           = 1'b1;
          w_last_grant_nxt = grant_icache;
          w_state_nxt      = arb_idle;
        end
      end

      arb_serve_d: begin
        pmem_write   = d_write;
        pmem_read    = d_read & ~d_write;
        pmem_address = d_address;
        pmem_wdata   = d_wdata;
        if (pmem_resp) begin
          d_resp           = 1'b1;
          w_last_grant_nxt = grant_dcache;
          w_state_nxt      = arb_idle;
        end
      end

      default: w_state_nxt = arb_idle;
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed vector table, alternation
// sequence, and randomized traffic against a transaction-ownership model.
module tb_cache_arbiter;

  logic         clk;
  logic         reset;
  logic         i_read;
  logic [15:0]  i_address;
  logic [127:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [15:0]  d_address;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int n_vec = 0;
  int n_err = 0;

  cache_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int rst, ir, dr, dw, rsp;
    int e_pr, e_pw, e_ir, e_dr, e_sel;
  } vec_t;

  function automatic logic [403:0] pack(input logic pr, input logic pw, input logic ir,
                                        input logic dr, input logic [15:0] a,
                                        input logic [127:0] wd, input logic [127:0] rd);
    return {pr, pw, ir, dr, a, wd, rd, rd};
  endfunction

  function automatic logic [403:0] actual();
    return {pmem_read, pmem_write, i_resp, d_resp, pmem_address, pmem_wdata, i_rdata, d_rdata};
  endfunction

  task automatic check(input string name, input logic [403:0] act, input logic [403:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [15:0]  IADDR = 16'h1230;
  localparam logic [15:0]  DADDR = 16'h4000;
  localparam logic [127:0] WDATA = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
  localparam logic [127:0] RDATA = {16{8'hA5}};

  vec_t vecs[$];

  initial begin
    logic [15:0]  ea;
    logic [127:0] ewd;
    int owner;
    int last;
    int mem_cnt;
    int got;
    int lat;
    int cyc;
    logic i_done;
    logic d_done;
    logic [403:0] exp;

    reset = 1'b1; i_read = 1'b1; d_read = 1'b0; d_write = 1'b0;
    i_address = IADDR; d_address = DADDR; d_wdata = WDATA;
    pmem_rdata = RDATA; pmem_resp = 1'b0;
    step();

    // rst, i, dr, dw, resp | pr, pw, i_resp, d_resp, addr sel (0 none, 1 icache, 2 dcache)
    vecs.push_back('{1,1,0,0,0, 0,0,0,0,0});
    vecs.push_back('{0,1,0,0,0, 0,0,0,0,0});
    vecs.push_back('{0,1,0,0,0, 1,0,0,0,1});
    vecs.push_back('{0,1,0,0,0, 1,0,0,0,1});
    vecs.push_back('{0,1,0,0,0, 1,0,0,0,1});
    vecs.push_back('{0,1,0,0,1, 1,0,1,0,1});
    vecs.push_back('{1,0,0,0,0, 0,0,0,0,0});
    vecs.push_back('{0,1,0,1,0, 0,0,0,0,0});
    vecs.push_back('{0,1,0,1,0, 0,1,0,0,2});
    vecs.push_back('{0,1,0,1,1, 0,1,0,1,2});
    vecs.push_back('{0,1,0,0,0, 0,0,0,0,0});
    vecs.push_back('{0,1,0,0,0, 1,0,0,0,1});
    vecs.push_back('{0,1,0,0,1, 1,0,1,0,1});
    vecs.push_back('{0,0,0,0,0, 0,0,0,0,0});
    vecs.push_back('{0,0,0,0,1, 0,0,0,0,0});
    vecs.push_back('{0,0,1,0,0, 0,0,0,0,0});
    vecs.push_back('{0,0,1,0,0, 1,0,0,0,2});
    vecs.push_back('{0,0,1,1,0, 0,1,0,0,2});
    vecs.push_back('{1,0,0,1,0, 0,1,0,0,2});
    vecs.push_back('{0,0,0,1,0, 0,0,0,0,0});
    vecs.push_back('{0,0,0,1,0, 0,1,0,0,2});
    vecs.push_back('{0,0,0,1,1, 0,1,0,1,2});
    vecs.push_back('{0,0,0,0,0, 0,0,0,0,0});

    foreach (vecs[k]) begin
      reset     = (vecs[k].rst != 0);
      i_read    = (vecs[k].ir != 0);
      d_read    = (vecs[k].dr != 0);
      d_write   = (vecs[k].dw != 0);
      pmem_resp = (vecs[k].rsp != 0);
      #1;
      ea  = (vecs[k].e_sel == 1) ? IADDR : ((vecs[k].e_sel == 2) ? DADDR : 16'h0);
      ewd = (vecs[k].e_sel == 2) ? WDATA : 128'h0;
      check($sformatf("vec%0d", k), actual(),
            pack(vecs[k].e_pr != 0, vecs[k].e_pw != 0, vecs[k].e_ir != 0,
                 vecs[k].e_dr != 0, ea, ewd, RDATA));
      step();
    end

    // Both caches held: grants must alternate D, I, D, I, D, I.
    reset = 1'b1; i_read = 1'b1; d_read = 1'b1; d_write = 1'b0; pmem_resp = 1'b0;
    step();
    reset = 1'b0;
    got = 0; lat = 0; cyc = 0;
    while (got < 6 && cyc < 200) begin
      pmem_resp = (lat == 2);
      #1;
      if (pmem_resp) begin
        check($sformatf("alt%0d", got), 404'({i_resp, d_resp}),
              404'((got % 2 == 0) ? 2'b01 : 2'b10));
        got++;
        lat = 0;
      end else if (pmem_read || pmem_write) begin
        lat++;
      end
      step();
      cyc++;
    end
    if (got < 6) begin
      n_vec++; n_err++;
      $display("FAIL alt_timeout: got %0d responses expected 6", got);
    end

    // Randomized traffic; owner is the cache the memory port must belong to next.
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    owner = 0; last = 1; mem_cnt = 0; i_done = 1'b0; d_done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (i_done) begin i_read = 1'b0; i_done = 1'b0; end
      if (d_done) begin d_read = 1'b0; d_write = 1'b0; d_done = 1'b0; end
      if (!i_read && $urandom_range(0, 2) == 0) begin
        i_read    = 1'b1;
        i_address = 16'($urandom) & 16'hFFF0;
      end
      if (!d_read && !d_write && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) d_write = 1'b1;
        else d_read = 1'b1;
        d_address = 16'($urandom) & 16'hFFF0;
        d_wdata   = {$urandom, $urandom, $urandom, $urandom};
      end
      pmem_resp  = (mem_cnt == 1) || (mem_cnt == 0 && $urandom_range(0, 15) == 0);
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (owner == 1)
        exp = pack(1'b1, 1'b0, pmem_resp, 1'b0, i_address, 128'h0, pmem_rdata);
      else if (owner == 2)
        exp = pack(d_read & ~d_write, d_write, 1'b0, pmem_resp, d_address, d_wdata, pmem_rdata);
      else
        exp = pack(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 128'h0, pmem_rdata);
      check($sformatf("rand%0d", c), actual(), exp);

      if (owner != 0 && pmem_resp) begin
        if (owner == 1) i_done = 1'b1;
        else d_done = 1'b1;
        last  = owner;
        owner = 0;
      end else if (owner == 0) begin
        if (i_read && (d_read || d_write)) owner = (last == 1) ? 2 : 1;
        else if (i_read) owner = 1;
        else if (d_read || d_write) owner = 2;
      end

      if (pmem_resp) mem_cnt = 0;
      else if (mem_cnt > 1) mem_cnt--;
      else if (mem_cnt == 0 && (pmem_read || pmem_write)) mem_cnt = $urandom_range(1, 5);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
